// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback unit: aligns and extends load data,
// selects the writeback source, flags bad loads and counts retired writes.
module mem_wb_writeback #(
   parameter int CNT_W    = 32,
   parameter bit X0_GUARD = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic             mem_RegWrite,
   input  logic             mem_MemtoReg,
   input  logic [4:0]       mem_RD,
   input  logic [2:0]       mem_Funct3,
   input  logic [63:0]      mem_ALUResult,
   input  logic [63:0]      mem_ReadData,
   output logic             RegWrite,
   output logic [4:0]       RD,
   output logic [63:0]      WriteData,
   output logic             wb_valid,
   output logic             load_fault,
   output logic [CNT_W-1:0] wb_retired
);

   localparam logic [2:0] F_LB  = 3'b000;
   localparam logic [2:0] F_LH  = 3'b001;
   localparam logic [2:0] F_LW  = 3'b010;
   localparam logic [2:0] F_LD  = 3'b011;
   localparam logic [2:0] F_LBU = 3'b100;
   localparam logic [2:0] F_LHU = 3'b101;
   localparam logic [2:0] F_LWU = 3'b110;

   // Pick the addressed byte/half/word out of the doubleword and extend it.
   function automatic logic [63:0] align_load(input logic [2:0]  f3,
                                              input logic [2:0]  off,
                                              input logic [63:0] dw);
      logic [63:0]        b_sh, h_sh, w_sh;
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      logic signed [31:0] w_s;
      logic signed [63:0] ext;
      b_sh = dw >> {off, 3'b000};
      h_sh = dw >> {off[2:1], 4'b0000};
      w_sh = dw >> {off[2], 5'b00000};
      b_s  = b_sh[7:0];
      h_s  = h_sh[15:0];
      w_s  = w_sh[31:0];
      case (f3)
         F_LB:    ext = b_s;
         F_LH:    ext = h_s;
         F_LW:    ext = w_s;
         F_LBU:   ext = {56'd0, b_sh[7:0]};
         F_LHU:   ext = {48'd0, h_sh[15:0]};
         F_LWU:   ext = {32'd0, w_sh[31:0]};
         default: ext = dw;
      endcase
      return ext;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
      logic bad;
      case (f3)
         F_LH, F_LHU: bad = off[0];
         F_LW, F_LWU: bad = |off[1:0];
         F_LD:        bad = |off;
         F_LB, F_LBU: bad = 1'b0;
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

   logic             vld_p1;
   logic             we_p1;
   logic             fault_p1;
   logic [4:0]       rd_p1;
   logic [63:0]      wdata_p1;
   logic [CNT_W-1:0] retired_p1;

   logic        cap_fault;
   logic        cap_we;
   logic [63:0] cap_wdata;

   always_comb begin
      cap_fault = mem_MemtoReg & misaligned(mem_Funct3, mem_ALUResult[2:0]);
      cap_we    = mem_valid & mem_RegWrite & ~cap_fault
                  & ~(X0_GUARD & (mem_RD == 5'd0));
      cap_wdata = mem_MemtoReg ? align_load(mem_Funct3, mem_ALUResult[2:0], mem_ReadData)
                               : mem_ALUResult;
   end

   // ---- MEM -> WB boundary ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1     <= 1'b0;
         we_p1      <= 1'b0;
         fault_p1   <= 1'b0;
         rd_p1      <= 5'd0;
         wdata_p1   <= 64'd0;
         retired_p1 <= '0;
      end else begin
         // The instruction leaving WB on this edge is the one counted.
         if (we_p1 && !stall && !flush)
            retired_p1 <= retired_p1 + CNT_W'(1);
         if (flush) begin
            vld_p1   <= 1'b0;
            we_p1    <= 1'b0;
            fault_p1 <= 1'b0;
         end else if (!stall) begin
            vld_p1   <= mem_valid;
            we_p1    <= cap_we;
            fault_p1 <= mem_valid & cap_fault;
            rd_p1    <= mem_RD;
            wdata_p1 <= cap_wdata;
         end
      end
   end

   assign wb_valid   = vld_p1;
   assign RegWrite   = we_p1;
   assign load_fault = fault_p1;
   assign RD         = rd_p1;
   assign WriteData  = wdata_p1;
   assign wb_retired = retired_p1;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomized and directed bench for mem_wb_writeback against a behavioural model.
module tb_mem_wb_writeback;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset, stall, flush;
   logic          mem_valid, mem_RegWrite, mem_MemtoReg;
   logic [4:0]    mem_RD;
   logic [2:0]    mem_Funct3;
   logic [63:0]   mem_ALUResult, mem_ReadData;
   logic          RegWrite;
   logic [4:0]    RD;
   logic [63:0]   WriteData;
   logic          wb_valid, load_fault;
   logic [CW-1:0] wb_retired;

   mem_wb_writeback #(.CNT_W(CW), .X0_GUARD(1'b1)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
      .mem_RD(mem_RD), .mem_Funct3(mem_Funct3), .mem_ALUResult(mem_ALUResult),
      .mem_ReadData(mem_ReadData), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
      .wb_valid(wb_valid), .load_fault(load_fault), .wb_retired(wb_retired)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Expected WB state
   logic          e_valid, e_we, e_fault;
   logic [4:0]    e_rd;
   logic [63:0]   e_wd;
   logic [CW-1:0] e_ret;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_load(input int f3, input logic [63:0] addr,
                                            input logic [63:0] dw);
      logic [63:0] v;
      int off;
      off = int'(addr % 8);
      case (f3)
         0, 4: begin
            v = (dw >> (8 * off)) & 64'hFF;
            if (f3 == 0 && v >= 64'd128) v = v - 64'd256;
         end
         1, 5: begin
            v = (dw >> (16 * (off / 2))) & 64'hFFFF;
            if (f3 == 1 && v >= 64'd32768) v = v - 64'd65536;
         end
         2, 6: begin
            v = (dw >> (32 * (off / 4))) & 64'hFFFF_FFFF;
            if (f3 == 2 && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
         end
         default: v = dw;
      endcase
      return v;
   endfunction

   function automatic bit ref_bad(input int f3, input logic [63:0] addr);
      int off;
      off = int'(addr % 8);
      return (f3 == 7) || ((f3 == 1 || f3 == 5) && off % 2 != 0)
          || ((f3 == 2 || f3 == 6) && off % 4 != 0) || (f3 == 3 && off != 0);
   endfunction

   task automatic model_reset();
      e_valid = 0; e_we = 0; e_fault = 0; e_rd = 0; e_wd = 0; e_ret = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_edge();
      bit bad;
      if (e_we && !stall && !flush) e_ret = e_ret + 1'b1;
      if (flush) begin
         e_valid = 0; e_we = 0; e_fault = 0;
      end else if (!stall) begin
         bad     = mem_MemtoReg && ref_bad(int'(mem_Funct3), mem_ALUResult);
         e_valid = mem_valid;
         e_fault = mem_valid && bad;
         e_we    = mem_valid && mem_RegWrite && !bad && (mem_RD != 0);
         e_rd    = mem_RD;
         e_wd    = mem_MemtoReg ? ref_load(int'(mem_Funct3), mem_ALUResult, mem_ReadData)
                                : mem_ALUResult;
      end
   endtask

   task automatic drive(input bit v, input bit rw, input bit m2r, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] dat,
                        input bit st, input bit fl);
      mem_valid = v; mem_RegWrite = rw; mem_MemtoReg = m2r; mem_RD = rd;
      mem_Funct3 = f3; mem_ALUResult = alu; mem_ReadData = dat; stall = st; flush = fl;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("wb_valid", 64'(wb_valid), 64'(e_valid));
      check("RegWrite", 64'(RegWrite), 64'(e_we));
      check("load_fault", 64'(load_fault), 64'(e_fault));
      check("wb_retired", 64'(wb_retired), 64'(e_ret));
      if (e_we) begin
         check("RD", 64'(RD), 64'(e_rd));
         check("WriteData", WriteData, e_wd);
      end
   endtask

   initial begin
      logic [63:0] held_wd;
      int guard;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #1;
      check("rst_valid", 64'(wb_valid), 0);
      check("rst_we", 64'(RegWrite), 0);
      check("rst_rd", 64'(RD), 0);
      check("rst_wd", WriteData, 0);
      check("rst_fault", 64'(load_fault), 0);
      check("rst_ret", 64'(wb_retired), 0);
      reset = 1'b0;

      // ALU writeback
      drive(1, 1, 0, 5'd5, 3'd0, 64'h1234, 64'h0, 0, 0);
      step();
      check("t1_we", 64'(RegWrite), 1);
      check("t1_rd", 64'(RD), 5);
      check("t1_wd", WriteData, 64'h1234);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("t1_ret", 64'(wb_retired), 1);

      // Byte and word loads with sign/zero extension
      drive(1, 1, 1, 5'd6, 3'b000, 64'h1003, 64'h0000_0000_80FF_0000, 0, 0);
      step();
      check("t2_lb", WriteData, 64'hFFFF_FFFF_FFFF_FF80);
      drive(1, 1, 1, 5'd6, 3'b100, 64'h1003, 64'h0000_0000_80FF_0000, 0, 0);
      step();
      check("t2_lbu", WriteData, 64'h80);
      drive(1, 1, 1, 5'd7, 3'b010, 64'h2004, 64'hDEAD_BEEF_0000_0000, 0, 0);
      step();
      check("t3_lw", WriteData, 64'hFFFF_FFFF_DEAD_BEEF);
      drive(1, 1, 1, 5'd7, 3'b110, 64'h2004, 64'hDEAD_BEEF_0000_0000, 0, 0);
      step();
      check("t3_lwu", WriteData, 64'h0000_0000_DEAD_BEEF);

      // Faulting loads
      drive(1, 1, 1, 5'd8, 3'b011, 64'h3002, 64'h1111_2222_3333_4444, 0, 0);
      step();
      check("t4_ld_fault", 64'(load_fault), 1);
      check("t4_ld_we", 64'(RegWrite), 0);
      drive(1, 1, 1, 5'd8, 3'b111, 64'h3000, 64'h1111_2222_3333_4444, 0, 0);
      step();
      check("t4_f7_fault", 64'(load_fault), 1);
      check("t4_f7_we", 64'(RegWrite), 0);

      // x0 guard, then flush beating stall
      drive(1, 1, 0, 5'd0, 3'd0, 64'h55, 64'h0, 0, 0);
      step();
      check("t5_x0_we", 64'(RegWrite), 0);
      drive(1, 1, 0, 5'd9, 3'd0, 64'h66, 64'h0, 1, 1);
      step();
      check("t5_flush_valid", 64'(wb_valid), 0);

      // Stall holds a write for three cycles, then reset mid-stall
      drive(1, 1, 0, 5'd10, 3'd0, 64'hABCD_0001, 64'h0, 0, 0);
      step();
      held_wd = WriteData;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 5'd11, 3'd0, 64'h9999, 64'h0, 1, 0);
         step();
         check("t6_hold_wd", WriteData, held_wd);
         check("t6_hold_we", 64'(RegWrite), 1);
      end
      reset = 1'b1;
      #1;
      model_reset();
      check("t6_rst_we", 64'(RegWrite), 0);
      check("t6_rst_valid", 64'(wb_valid), 0);
      check("t6_rst_wd", WriteData, 0);
      check("t6_rst_ret", 64'(wb_retired), 0);
      #2;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Randomized mix
      for (int i = 0; i < 400; i++) begin
         logic [63:0] alu;
         alu = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) alu[2:0] = 3'd0;
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               3'($urandom_range(0, 7)), alu, {$urandom, $urandom},
               $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
         step();
      end

      // Counter wrap
      guard = 0;
      drive(1, 1, 0, 5'd3, 3'd0, 64'h77, 64'h0, 0, 0);
      while (!(e_ret == {CW{1'b1}} && e_we) && guard < 600) begin
         step();
         guard++;
      end
      check("t7_reach_max", 64'(guard < 600), 1);
      step();
      check("t7_wrap", 64'(wb_retired), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
